// File: rtl/mem_arbiter.sv
// mem_arbiter: registered two-requester arbiter (icache / dcache) in front of
// a single-ported RAM. A grant is held for as long as its owner keeps
// requesting, so multi-word fills and write-backs are never interleaved.
// Also keeps per-requester completion counters and a sticky RAM error flag.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    // instruction cache
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    // data cache
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    // RAM
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    // status
    output logic [31:0]       icount,
    output logic [31:0]       dcount,
    output logic              ramerr
);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    // Index of each requester in the per-requester arrays below.
    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   prio_reg;       // tie winner: 0 = data, 1 = instruction
    logic   prio_next;
    logic   ramerr_reg;

    logic   dreq;
    logic   ireq;
    logic   granted;
    logic   err_now;

    logic [1:0]  owner;       // one-hot: which requester currently holds the RAM
    logic [1:0]  access;      // owner's RAM access completes this cycle
    logic [31:0] count_reg [2];

    assign dreq = dREN | dWEN;
    assign ireq = iREN;

    assign owner[REQ_I] = (state_reg == IGRANT);
    assign owner[REQ_D] = (state_reg == DGRANT);
    assign granted      = owner[REQ_I] | owner[REQ_D];
    assign err_now      = granted && (ramstate == RS_ERROR);

    // Per-requester completion detection and wrapping transfer counters.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign access[gi] = owner[gi] && (ramstate == RS_ACCESS);

            // Count one transfer per ACCESS cycle seen while owning the RAM.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    count_reg[gi] <= '0;
                end else if (access[gi]) begin
                    count_reg[gi] <= count_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign icount = count_reg[REQ_I];
    assign dcount = count_reg[REQ_D];

    // Wait is released only in the owner's ACCESS cycle; ERROR keeps it high.
    assign iwait = ~access[REQ_I];
    assign dwait = ~access[REQ_D];

    // Read data is a straight pass-through; caches sample it when wait drops.
    assign iload = ramload;
    assign dload = ramload;

    // The error flag is visible in the ERROR cycle itself and sticks afterwards.
    assign ramerr = ramerr_reg | err_now;

    // State, tie-break priority and sticky error registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            prio_reg   <= 1'b0;
            ramerr_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
            if (err_now) begin
                ramerr_reg <= 1'b1;
            end
        end
    end

    // Next-state selection and RAM port steering from the current owner.
    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;

        case (state_reg)
            IDLE: begin
                if (dreq && ireq) begin
                    state_next = prio_reg ? IGRANT : DGRANT;
                end else if (dreq) begin
                    state_next = DGRANT;
                end else if (ireq) begin
                    state_next = IGRANT;
                end
            end

            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                // A simultaneous read+write request is treated as a write.
                ramREN   = dREN & ~dWEN;
                if (!dreq) begin
                    prio_next  = 1'b1;
                    state_next = ireq ? IGRANT : IDLE;
                end
            end

            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!ireq) begin
                    prio_next  = 1'b0;
                    state_next = dreq ? DGRANT : IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
